abp_tx_scheduler: RTL and testbench
===================================

# abp_tx_scheduler

Sender-side Alternating Bit Protocol controller. Owns the current sequence state (value + alternating bit), issues hyperdata to the ABP packet transmitter over a valid/ready handshake, waits for the matching acknowledgement from the receive parser, and retransmits on timeout up to a bounded retry count. It sits between the host enable/status logic and the packet transmitter's hyperdata input.

## Interface

- VALUE_SIZE, 4, bytes in the ABP counter value; value width is 8*VALUE_SIZE.
- TIMEOUT_CYCLES, 1024, idle-wait cycles before retransmission; must be ≥ 2.
- MAX_RETRIES, 8, retransmissions allowed per sequence number before failure; must be ≥ 1.

- aclk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  permission to start new sequence numbers.
- m_abp_valid  out  1  hyperdata valid to packet transmitter.
- m_abp_ready  in  1  transmitter accepts hyperdata.
- m_abp_value  out  8*VALUE_SIZE  current sequence value.
- m_abp_bit  out  1  current alternating bit.
- tx_busy  in  1  transmitter is serialising a packet.
- s_ack_valid  in  1  one-cycle ack strobe from receive parser; always accepted.
- s_ack_value  in  8*VALUE_SIZE  value carried by the received ack.
- s_ack_bit  in  1  alternating bit of the received ack.
- busy  out  1  state is ISSUE or WAIT_ACK.
- retry_count  out  $clog2(MAX_RETRIES+1)  retransmissions of the current sequence number.
- acked_count  out  32  total matched acks; wraps at 2^32.
- stale_ack  out  1  one-cycle pulse on a non-matching ack in WAIT_ACK.
- error_retry_exhausted  out  1  high while in FAILED.

## Operation

- States: IDLE, ISSUE, WAIT_ACK, FAILED.
- IDLE: m_abp_valid=0. enable=1 → ISSUE.
- ISSUE: m_abp_valid=1; m_abp_value/m_abp_bit = seq_value/seq_bit, held stable until handshake. m_abp_valid && m_abp_ready → WAIT_ACK, timer cleared. Deasserting enable does not withdraw valid.
- WAIT_ACK:
  - Timer increments each cycle tx_busy=0 and holds while tx_busy=1.
  - Ack match: s_ack_valid && s_ack_bit==seq_bit && s_ack_value==seq_value+1 (mod 2^(8*VALUE_SIZE); the transmitter emits value+1 on the wire). On match: seq_value ← s_ack_value, seq_bit ← ~seq_bit, retry_count ← 0, acked_count +1. Next state is ISSUE if enable=1, else IDLE.
  - Non-matching ack: stale_ack pulses for one cycle; state, sequence and timer unchanged.
  - Timeout: timer reaches TIMEOUT_CYCLES-1 with no match. If retry_count==MAX_RETRIES → FAILED; else retry_count +1 → ISSUE with unchanged seq_value/seq_bit. Retransmission ignores enable.
  - Ack match and timeout in the same cycle: the match wins.
- FAILED: error_retry_exhausted=1, m_abp_valid=0, all acks ignored (no stale_ack). Exit only by reset.
- Arithmetic: sequence value wraps modulo 2^(8*VALUE_SIZE); the timer is $clog2(TIMEOUT_CYCLES) bits wide.

## Timing

- All outputs are registered. Reset values: m_abp_valid=0, m_abp_value=0, m_abp_bit=0, busy=0, retry_count=0, acked_count=0, stale_ack=0, error_retry_exhausted=0; state=IDLE, seq_value=0, seq_bit=0, timer=0.
- IDLE with enable=1 at edge N: m_abp_valid=1 after edge N+1.
- Handshake at edge N: m_abp_valid=0 after edge N.
- Ack match sampled at edge N: new seq_value/seq_bit and acked_count visible after edge N. If enable=1, m_abp_valid re-asserts after edge N+1.
- Timeout: with tx_busy=0 throughout, the timeout fires at the TIMEOUT_CYCLES-th edge after entering WAIT_ACK. m_abp_valid re-asserts after the next edge.
- Reset mid-operation: any state → IDLE on that edge, and m_abp_valid drops. A transfer already handed to the transmitter is not recalled.

## Test plan

- Basic exchange (VALUE_SIZE=4, reset values): enable=1, ready=1 → issue value 0/bit 0. Ack (1, bit 0) → issue value 1/bit 1, acked_count=1.
- Stale ack: in WAIT_ACK with seq 1/bit 1, ack (2, bit 0) → stale_ack pulses once, no state change. Then ack (2, bit 1) → matched, seq 2/bit 0.
- Timeout/retry (TIMEOUT_CYCLES=16, MAX_RETRIES=2, no acks, tx_busy=0) → re-issue of the same value/bit every ~17 cycles, retry_count 1 then 2. Third timeout → FAILED, error_retry_exhausted=1, no further valid.
- tx_busy hold: tx_busy=1 for 10 cycles after handshake → timeout fires 10 cycles later than in the previous case.
- Boundary: seq_value=0xFFFFFFFF, bit 0; ack (0x00000000, bit 0) → match, next issue 0x00000000/bit 1. Ack coincident with timeout cycle → match wins, retry_count=0.
- Backpressure/reset: hold ready=0 for 5 cycles and drop enable → valid, value and bit stay stable until ready. Assert reset while in WAIT_ACK → IDLE next cycle, all outputs at reset values.

Source files
------------

// File: rtl/abp_tx_scheduler.sv
// abp_tx_scheduler: sender side of the Alternating Bit Protocol.
// Holds the current sequence value/bit, offers it to the packet transmitter
// over valid/ready, waits for the matching ack (value+1, same bit) and
// retransmits on timeout until the retry budget is spent.
module abp_tx_scheduler #(
    parameter int VALUE_SIZE     = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_RETRIES    = 8
) (
    input  logic                             aclk,
    input  logic                             reset,
    input  logic                             enable,
    output logic                             m_abp_valid,
    input  logic                             m_abp_ready,
    output logic [8*VALUE_SIZE-1:0]          m_abp_value,
    output logic                             m_abp_bit,
    input  logic                             tx_busy,
    input  logic                             s_ack_valid,
    input  logic [8*VALUE_SIZE-1:0]          s_ack_value,
    input  logic                             s_ack_bit,
    output logic                             busy,
    output logic [$clog2(MAX_RETRIES+1)-1:0] retry_count,
    output logic [31:0]                      acked_count,
    output logic                             stale_ack,
    output logic                             error_retry_exhausted
);

    localparam int VW = 8 * VALUE_SIZE;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int RW = $clog2(MAX_RETRIES + 1);

    localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_FAILED = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [TW-1:0] timer;

    logic handshake;
    logic ack_seen;
    logic ack_match;
    logic timeout;

    // m_abp_value/m_abp_bit are the sequence registers themselves, so the
    // offered hyperdata cannot move while valid is up.
    assign handshake = (state == S_ISSUE) && m_abp_valid && m_abp_ready;
    assign ack_seen  = (state == S_WAIT) && s_ack_valid;
    assign ack_match = ack_seen && (s_ack_bit == m_abp_bit) &&
                       (s_ack_value == m_abp_value + VW'(1));
    // Only cycles where the transmitter is idle count towards the timeout.
    assign timeout   = (state == S_WAIT) && !tx_busy && (timer == TIMER_LAST);

    // Next-state selection; a match beats a coincident timeout.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (enable) state_nx = S_ISSUE;
            S_ISSUE:  if (handshake) state_nx = S_WAIT;
            S_WAIT: begin
                if (ack_match)
                    state_nx = enable ? S_ISSUE : S_IDLE;
                else if (timeout)
                    state_nx = (retry_count == RETRY_LIMIT) ? S_FAILED : S_ISSUE;
            end
            S_FAILED: state_nx = S_FAILED;
            default:  state_nx = S_IDLE;
        endcase
    end

    // State register and the status flags derived from the state being entered.
    always_ff @(posedge aclk) begin
        if (reset) begin
            state                 <= S_IDLE;
            busy                  <= 1'b0;
            error_retry_exhausted <= 1'b0;
            stale_ack             <= 1'b0;
        end else begin
            state                 <= state_nx;
            busy                  <= (state_nx == S_ISSUE) || (state_nx == S_WAIT);
            error_retry_exhausted <= (state_nx == S_FAILED);
            stale_ack             <= ack_seen && !ack_match;
        end
    end

    // Valid rises one cycle into ISSUE and drops on the handshake edge;
    // the ack timer runs only in WAIT_ACK and is cleared everywhere else.
    always_ff @(posedge aclk) begin
        if (reset) begin
            m_abp_valid <= 1'b0;
            timer       <= '0;
        end else begin
            m_abp_valid <= (state == S_ISSUE) && !handshake;
            if (state == S_WAIT) begin
                if (!tx_busy)
                    timer <= timer + TW'(1);
            end else begin
                timer <= '0;
            end
        end
    end

    // Sequence advance on a matched ack, retry accounting on timeout.
    always_ff @(posedge aclk) begin
        if (reset) begin
            m_abp_value <= '0;
            m_abp_bit   <= 1'b0;
            retry_count <= '0;
            acked_count <= '0;
        end else if (ack_match) begin
            m_abp_value <= s_ack_value;
            m_abp_bit   <= ~m_abp_bit;
            retry_count <= '0;
            acked_count <= acked_count + 32'd1;
        end else if (timeout && (retry_count != RETRY_LIMIT)) begin
            retry_count <= retry_count + RW'(1);
        end
    end

endmodule

// File: tb/tb_abp_tx_scheduler.sv
// Randomized scoreboard bench for abp_tx_scheduler.
// A transaction-level reference model runs alongside the stimulus and queues
// the expected outputs per cycle plus every expected handshake; a separate
// monitor pops and compares. VALUE_SIZE=1 keeps the sequence value 8 bits so
// the wrap from 0xFF to 0x00 is reached within a short run.
module tb_abp_tx_scheduler;

    localparam int VS = 1;
    localparam int T  = 16;
    localparam int MR = 2;
    localparam int VW = 8 * VS;
    localparam int RW = $clog2(MR + 1);

    localparam int PH_IDLE   = 0;
    localparam int PH_OFFER  = 1;
    localparam int PH_WAIT   = 2;
    localparam int PH_FAILED = 3;

    logic          aclk;
    logic          reset;
    logic          enable;
    logic          m_abp_valid;
    logic          m_abp_ready;
    logic [VW-1:0] m_abp_value;
    logic          m_abp_bit;
    logic          tx_busy;
    logic          s_ack_valid;
    logic [VW-1:0] s_ack_value;
    logic          s_ack_bit;
    logic          busy;
    logic [RW-1:0] retry_count;
    logic [31:0]   acked_count;
    logic          stale_ack;
    logic          error_retry_exhausted;

    abp_tx_scheduler #(
        .VALUE_SIZE    (VS),
        .TIMEOUT_CYCLES(T),
        .MAX_RETRIES   (MR)
    ) dut (
        .aclk                 (aclk),
        .reset                (reset),
        .enable               (enable),
        .m_abp_valid          (m_abp_valid),
        .m_abp_ready          (m_abp_ready),
        .m_abp_value          (m_abp_value),
        .m_abp_bit            (m_abp_bit),
        .tx_busy              (tx_busy),
        .s_ack_valid          (s_ack_valid),
        .s_ack_value          (s_ack_value),
        .s_ack_bit            (s_ack_bit),
        .busy                 (busy),
        .retry_count          (retry_count),
        .acked_count          (acked_count),
        .stale_ack            (stale_ack),
        .error_retry_exhausted(error_retry_exhausted)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct packed {
        logic          valid;
        logic [VW-1:0] value;
        logic          bitv;
        logic          busy;
        logic [RW-1:0] retry;
        logic [31:0]   acked;
        logic          stale;
        logic          err;
    } snap_t;

    typedef struct packed {
        logic [VW-1:0] value;
        logic          bitv;
    } hs_t;

    snap_t snap_q[$];
    hs_t   hs_q[$];
    int    tests   = 0;
    int    fails   = 0;
    bit    started = 0;
    int    cyc     = 0;

    always @(posedge aclk) cyc <= cyc + 1;

    // Reference model: protocol phase, offered item, retries, acks, and the
    // number of transmitter-idle cycles spent waiting for the current ack.
    int            ph     = PH_IDLE;
    bit            mv     = 0;
    logic [VW-1:0] mval   = '0;
    bit            mbit   = 0;
    int            mretry = 0;
    int unsigned   macked = 0;
    int            waited = 0;
    bit            mstale = 0;

    task automatic model_edge(input bit rst, input bit en, input bit rdy, input bit txb,
                              input bit av, input logic [VW-1:0] aval, input bit abit);
        hs_t h;
        mstale = 0;
        if (rst) begin
            ph = PH_IDLE; mv = 0; mval = '0; mbit = 0;
            mretry = 0; macked = 0; waited = 0;
        end else begin
            case (ph)
                PH_IDLE: if (en) ph = PH_OFFER;
                PH_OFFER: begin
                    if (mv && rdy) begin
                        h.value = mval; h.bitv = mbit;
                        hs_q.push_back(h);
                        mv = 0; waited = 0; ph = PH_WAIT;
                    end else begin
                        mv = 1;
                    end
                end
                PH_WAIT: begin
                    if (av && abit == mbit && aval == VW'(mval + 1)) begin
                        mval = aval; mbit = !mbit; mretry = 0; macked++;
                        ph = en ? PH_OFFER : PH_IDLE;
                    end else begin
                        if (av) mstale = 1;
                        if (!txb) begin
                            waited++;
                            if (waited == T) begin
                                if (mretry == MR) ph = PH_FAILED;
                                else begin mretry++; ph = PH_OFFER; end
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic drive(input bit rst, input bit en, input bit rdy, input bit txb,
                         input bit av, input logic [VW-1:0] aval, input bit abit);
        snap_t s;
        @(negedge aclk);
        reset = rst; enable = en; m_abp_ready = rdy; tx_busy = txb;
        s_ack_valid = av; s_ack_value = aval; s_ack_bit = abit;
        model_edge(rst, en, rdy, txb, av, aval, abit);
        s.valid = mv;   s.value = mval; s.bitv = mbit;
        s.busy  = (ph == PH_OFFER) || (ph == PH_WAIT);
        s.retry = RW'(mretry); s.acked = macked; s.stale = mstale;
        s.err   = (ph == PH_FAILED);
        snap_q.push_back(s);
        started = 1;
    endtask

    // One random cycle; while an ack is awaited the responder may send the
    // matching ack or one of three stale forms.
    task automatic rand_cycle(input int p_en, input int p_rdy, input int p_txb,
                              input int p_ack, input int p_stale, input int p_noise);
        bit en, rdy, txb, av, abit;
        logic [VW-1:0] aval;
        int r;
        en   = $urandom_range(0, 99) < p_en;
        rdy  = $urandom_range(0, 99) < p_rdy;
        txb  = $urandom_range(0, 99) < p_txb;
        av   = 0;
        aval = VW'($urandom);
        abit = 1'($urandom);
        if (ph == PH_WAIT) begin
            r = $urandom_range(0, 99);
            if (r < p_ack) begin
                av = 1; aval = mval + VW'(1); abit = mbit;
            end else if (r < p_ack + p_stale) begin
                av = 1;
                case ($urandom_range(0, 2))
                    0:       begin aval = mval + VW'(1); abit = !mbit; end
                    1:       begin aval = mval + VW'(2); abit = mbit;  end
                    default: begin aval = mval;          abit = mbit;  end
                endcase
            end
        end else if ($urandom_range(0, 99) < p_noise) begin
            av = 1;
        end
        drive(0, en, rdy, txb, av, aval, abit);
    endtask

    // Monitor: every cycle pops the expected output snapshot; on each
    // observed handshake pops the expected offered value/bit.
    initial begin
        bit            pv;
        logic [VW-1:0] pval;
        bit            pb;
        snap_t         got, exp;
        hs_t           h;
        pv = 0; pval = '0; pb = 0;
        forever begin
            @(posedge aclk);
            #1;
            if (!started) continue;
            if (pv && m_abp_ready && !reset) begin
                tests++;
                if (hs_q.size() == 0) begin
                    fails++;
                    $display("FAIL handshake@%0d: got value=%h bit=%b, required no transfer", cyc, pval, pb);
                end else begin
                    h = hs_q.pop_front();
                    if (pval !== h.value || pb !== h.bitv) begin
                        fails++;
                        $display("FAIL handshake@%0d: got value=%h bit=%b, required value=%h bit=%b",
                                 cyc, pval, pb, h.value, h.bitv);
                    end
                end
            end
            got = {m_abp_valid, m_abp_value, m_abp_bit, busy, retry_count,
                   acked_count, stale_ack, error_retry_exhausted};
            tests++;
            if (snap_q.size() == 0) begin
                fails++;
                $display("FAIL outputs@%0d: no expected snapshot queued", cyc);
            end else begin
                exp = snap_q.pop_front();
                if (got !== exp) begin
                    fails++;
                    $display("FAIL outputs@%0d: got valid=%b value=%h bit=%b busy=%b retry=%0d acked=%0d stale=%b err=%b, required valid=%b value=%h bit=%b busy=%b retry=%0d acked=%0d stale=%b err=%b",
                             cyc, got.valid, got.value, got.bitv, got.busy, got.retry, got.acked, got.stale, got.err,
                             exp.valid, exp.value, exp.bitv, exp.busy, exp.retry, exp.acked, exp.stale, exp.err);
                end
            end
            pv = m_abp_valid; pval = m_abp_value; pb = m_abp_bit;
        end
    end

    // Stimulus
    initial begin
        bit hit;
        reset = 1; enable = 0; m_abp_ready = 0; tx_busy = 0;
        s_ack_valid = 0; s_ack_value = '0; s_ack_bit = 0;

        repeat (3) drive(1, 0, 0, 0, 0, '0, 0);
        repeat (2) drive(0, 0, 1, 0, 0, '0, 0);

        // Long mixed traffic: hundreds of acks, so the 8-bit value wraps.
        repeat (3000) rand_cycle(90, 70, 20, 35, 10, 5);

        // Ack lands exactly on the timeout cycle: the match must win.
        repeat (250) begin
            hit = (ph == PH_WAIT) && (waited == T - 1);
            drive(0, 1, 1, 0, hit, mval + VW'(1), mbit);
        end

        // No acks: retries run out and the block parks in FAILED, where
        // stray acks must not raise stale_ack.
        for (int i = 0; i < 3000 && ph != PH_FAILED; i++) rand_cycle(70, 50, 30, 0, 5, 20);
        repeat (60) rand_cycle(50, 50, 30, 0, 5, 20);
        drive(1, 0, 0, 0, 0, '0, 0);

        // Reset while waiting for an ack.
        for (int i = 0; i < 20 && ph != PH_WAIT; i++) drive(0, 1, 1, 0, 0, '0, 0);
        repeat (3) drive(0, 1, 1, 0, 0, '0, 0);
        drive(1, 1, 1, 0, 0, '0, 0);
        repeat (3) drive(0, 0, 1, 0, 0, '0, 0);

        // Backpressure with enable dropped: the offer must hold steady.
        for (int i = 0; i < 10 && !mv; i++) drive(0, 1, 0, 0, 0, '0, 0);
        repeat (5) drive(0, 0, 0, 0, 0, '0, 0);
        drive(0, 0, 1, 0, 0, '0, 0);
        repeat (3) drive(0, 0, 0, 0, 0, '0, 0);
        drive(0, 0, 0, 0, 1, mval + VW'(1), mbit);
        repeat (5) drive(0, 0, 0, 0, 0, '0, 0);

        // Heavy transmitter activity and frequent stale acks.
        repeat (1500) rand_cycle(60, 40, 60, 20, 15, 10);
        repeat (3) drive(0, 0, 0, 0, 0, '0, 0);

        @(posedge aclk);
        #2;
        started = 0;
        tests++;
        if (snap_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d output snapshots left, required 0", snap_q.size());
        end
        tests++;
        if (hs_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected handshakes not seen, required 0", hs_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
